// File: rtl/gnt_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gnt_burst_ctrl
// Description : Burst controller downstream of a 4-way arbiter. Passes raw
//               requests to the arbiter while idle, latches a one-hot grant as
//               the bus owner, muxes the owner's valid/data burst onto a
//               shared slave port, counts beats and pulses done to the owner
//               after the last beat. Flags non-one-hot grants and bursts that
//               stall for TMO consecutive cycles.
// Ports       : clk, rst_n (async active-low)
//               req_in[3:0] -> req_out[3:0]  request gating to the arbiter
//               gnt[3:0]                     registered grant from the arbiter
//               m_len/m_valid/m_data/m_ready per-master burst interface
//               s_valid/s_data/s_ready       shared slave port
//               busy, owner[1:0]             transfer status / bus owner
//               done[3:0], gnt_err, tmo_err  registered one-cycle pulses
// Revision    : 1.0 - initial release
// ============================================================================
module gnt_burst_ctrl #(
    parameter int DW    = 32,
    parameter int LEN_W = 4,
    parameter int TMO   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_in,
    output logic [3:0]        req_out,
    input  logic [3:0]        gnt,
    input  logic [4*LEN_W-1:0] m_len,
    input  logic [3:0]        m_valid,
    input  logic [4*DW-1:0]   m_data,
    output logic [3:0]        m_ready,
    output logic              s_valid,
    output logic [DW-1:0]     s_data,
    input  logic              s_ready,
    output logic              busy,
    output logic [1:0]        owner,
    output logic [3:0]        done,
    output logic              gnt_err,
    output logic              tmo_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    // Abort fires on the edge that would take the stall counter to TMO.
    localparam logic [7:0] c_TMO_LAST = 8'(TMO - 1);

    state_t            r_state;
    logic [1:0]        r_owner;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [7:0]        r_tmo_cnt;
    logic [3:0]        r_done;
    logic              r_gnt_err;
    logic              r_tmo_err;

    logic [LEN_W-1:0]  w_len  [4];
    logic [DW-1:0]     w_data [4];
    logic              w_xfer;
    logic              w_gnt_onehot;
    logic              w_gnt_multi;
    logic [1:0]        w_gnt_idx;
    logic              w_s_valid;
    logic              w_beat;

    // Flatten the packed per-master buses into indexable arrays.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_len[gi]  = m_len[gi*LEN_W +: LEN_W];
        assign w_data[gi] = m_data[gi*DW +: DW];
    end

    assign w_xfer       = (r_state == S_XFER);
    assign w_gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
    assign w_gnt_multi  = (gnt != 4'd0) && !w_gnt_onehot;

    always_comb begin
        w_gnt_idx = 2'd0;
        case (gnt)
            4'b0010: w_gnt_idx = 2'd1;
            4'b0100: w_gnt_idx = 2'd2;
            4'b1000: w_gnt_idx = 2'd3;
            default: w_gnt_idx = 2'd0;
        endcase
    end

    assign w_s_valid = w_xfer & m_valid[r_owner];
    assign w_beat    = w_s_valid & s_ready;

    // Requests are hidden from the arbiter for the whole burst so it cannot
    // prepare a grant that would be taken mid-burst.
    assign req_out = w_xfer ? 4'b0000 : req_in;
    assign m_ready = w_xfer ? (4'({3'b000, s_ready}) << r_owner) : 4'b0000;
    assign s_valid = w_s_valid;
    assign s_data  = w_xfer ? w_data[r_owner] : '0;
    assign busy    = w_xfer;
    assign owner   = r_owner;
    assign done    = r_done;
    assign gnt_err = r_gnt_err;
    assign tmo_err = r_tmo_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 2'd0;
            r_beat_cnt <= '0;
            r_tmo_cnt  <= 8'd0;
            r_done     <= 4'b0000;
            r_gnt_err  <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_done    <= 4'b0000;
            r_gnt_err <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_multi) begin
                        r_gnt_err <= 1'b1;
                    end else if (w_gnt_onehot && ((gnt & req_in) != 4'd0)) begin
                        // A grant whose request has already dropped is stale.
                        r_owner    <= w_gnt_idx;
                        r_beat_cnt <= w_len[w_gnt_idx];
                        r_tmo_cnt  <= 8'd0;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        r_tmo_cnt <= 8'd0;
                        if (r_beat_cnt == '0) begin
                            r_done  <= 4'b0001 << r_owner;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 1'b1;
                        end
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gnt_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnt_burst_ctrl
// Description : Scoreboard bench for gnt_burst_ctrl. A small registered
//               fixed-priority arbiter (lowest index wins) closes the loop
//               between req_out and gnt, with an override to force illegal
//               grants. Stimulus pushes expected beats and pulses; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnt_burst_ctrl;

    localparam int DW    = 32;
    localparam int LEN_W = 4;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req_in;
    logic [3:0]        req_out;
    logic [3:0]        gnt;
    logic [4*LEN_W-1:0] m_len;
    logic [3:0]        m_valid;
    logic [4*DW-1:0]   m_data;
    logic [3:0]        m_ready;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic              busy;
    logic [1:0]        owner;
    logic [3:0]        done;
    logic              gnt_err;
    logic              tmo_err;

    logic [LEN_W-1:0]  ml [4];
    logic [DW-1:0]     md [4];
    logic [3:0]        r_arb_gnt;
    logic              force_en;
    logic [3:0]        force_val;
    int                cyc;
    int                n_checks;
    int                n_errors;

    typedef struct {
        logic [1:0]    own;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct {
        logic [3:0] val;
        int         cyc;
    } pulse_t;

    beat_t  exp_beat[$];
    pulse_t exp_done[$];
    int     exp_gerr[$];
    int     exp_tmo[$];

    assign m_len  = {ml[3], ml[2], ml[1], ml[0]};
    assign m_data = {md[3], md[2], md[1], md[0]};
    assign gnt    = force_en ? force_val : r_arb_gnt;

    gnt_burst_ctrl #(.DW(DW), .LEN_W(LEN_W), .TMO(255)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .req_out (req_out),
        .gnt     (gnt),
        .m_len   (m_len),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .owner   (owner),
        .done    (done),
        .gnt_err (gnt_err),
        .tmo_err (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered fixed-priority arbiter: lowest requesting index wins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_arb_gnt <= 4'b0000;
        else        r_arb_gnt <= req_out & (~req_out + 4'd1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call from posedge+#1 or later with t > cyc; returns at posedge(t)+#1.
    task automatic wait_cyc(input int t);
        int n;
        n = t - cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares every presented beat and pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) begin
                if (exp_beat.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL beat_unexpected: data 0x%0h owner %0d at cycle %0d", s_data, owner, cyc);
                end else begin
                    beat_t b;
                    b = exp_beat.pop_front();
                    chk("beat_data", s_data, b.data);
                    chk("beat_owner", 32'(owner), 32'(b.own));
                    chk("beat_m_ready", 32'(m_ready), 32'(4'b0001 << b.own));
                end
            end
            if (done != 4'b0000) begin
                if (exp_done.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL done_unexpected: got 0x%0h expected none at cycle %0d", done, cyc);
                end else begin
                    pulse_t p;
                    p = exp_done.pop_front();
                    chk("done_value", 32'(done), 32'(p.val));
                    chk("done_cycle", cyc, p.cyc);
                end
            end
            if (gnt_err) begin
                if (exp_gerr.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL gnt_err_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    chk("gnt_err_cycle", cyc, exp_gerr.pop_front());
                end
            end
            if (tmo_err) begin
                if (exp_tmo.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL tmo_err_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    chk("tmo_err_cycle", cyc, exp_tmo.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_in    = 4'b0101;
        s_ready   = 1'b0;
        m_valid   = 4'b0000;
        force_en  = 1'b0;
        force_val = 4'b0000;
        for (int i = 0; i < 4; i++) ml[i] = '0;
        md[0] = 32'hA5A5_0000;
        md[1] = 32'h1111_1111;
        md[2] = 32'h2222_2222;
        md[3] = 32'h3333_3333;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_gnt_err", 32'(gnt_err), 0);
        chk("rst_tmo_err", 32'(tmo_err), 0);
        chk("rst_req_out", 32'(req_out), 32'h5);
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_s_data", s_data, 0);
        rst_n   = 1'b1;
        req_in  = 4'b0000;
        m_valid = 4'b1111;
        s_ready = 1'b1;
        step(); step();

        // 1) Master 0, 4 beats, done 6 cycles after the request
        e = cyc;
        ml[0]  = 4'd3;
        req_in = 4'b0001;
        for (int i = 0; i < 4; i++) exp_beat.push_back('{own: 2'd0, data: md[0]});
        exp_done.push_back('{val: 4'b0001, cyc: e + 6});
        wait_cyc(e + 2); req_in = 4'b0000; #1;
        chk("t1_busy_first", 32'(busy), 1);
        chk("t1_owner", 32'(owner), 0);
        wait_cyc(e + 5); #1;
        chk("t1_busy_last", 32'(busy), 1);
        wait_cyc(e + 6); #1;
        chk("t1_busy_after", 32'(busy), 0);
        step(); step();

        // 2) Requests masked during master 1 burst, then arbitration resumes
        e = cyc;
        ml[1]  = 4'd0;
        ml[2]  = 4'd1;
        req_in = 4'b0010;
        exp_beat.push_back('{own: 2'd1, data: md[1]});
        exp_done.push_back('{val: 4'b0010, cyc: e + 3});
        exp_beat.push_back('{own: 2'd1, data: md[1]});
        exp_done.push_back('{val: 4'b0010, cyc: e + 6});
        exp_beat.push_back('{own: 2'd2, data: md[2]});
        exp_beat.push_back('{own: 2'd2, data: md[2]});
        exp_done.push_back('{val: 4'b0100, cyc: e + 10});
        wait_cyc(e + 2); req_in = 4'b0110; #1;
        chk("t2_req_out_masked", 32'(req_out), 0);
        wait_cyc(e + 3); #1;
        chk("t2_req_out_idle", 32'(req_out), 32'h6);
        chk("t2_busy_idle", 32'(busy), 0);
        wait_cyc(e + 5); req_in = 4'b0100; #1;
        chk("t2_busy_m1", 32'(busy), 1);
        chk("t2_owner_m1", 32'(owner), 1);
        wait_cyc(e + 8); req_in = 4'b0000; #1;
        chk("t2_busy_m2", 32'(busy), 1);
        chk("t2_owner_m2", 32'(owner), 2);
        wait_cyc(e + 10); #1;
        chk("t2_busy_end", 32'(busy), 0);
        step(); step();

        // 3) Illegal grant, then a stale grant whose request dropped
        e = cyc;
        req_in    = 4'b0011;
        force_en  = 1'b1;
        force_val = 4'b0011;
        exp_gerr.push_back(e + 1);
        wait_cyc(e + 1); force_en = 1'b0; req_in = 4'b0000; #1;
        chk("t3_busy", 32'(busy), 0);
        chk("t3_owner", 32'(owner), 2);
        chk("t3_m_ready", 32'(m_ready), 0);
        wait_cyc(e + 3); #1;
        chk("t3_busy_stale", 32'(busy), 0);
        chk("t3_owner_stale", 32'(owner), 2);
        step();

        // 4) Owner 2 stalls for 255 cycles -> timeout
        e = cyc;
        ml[2]   = 4'd1;
        m_valid = 4'b1011;
        req_in  = 4'b0100;
        exp_tmo.push_back(e + 257);
        wait_cyc(e + 2); req_in = 4'b0000; #1;
        chk("t4_busy", 32'(busy), 1);
        chk("t4_owner", 32'(owner), 2);
        wait_cyc(e + 256); #1;
        chk("t4_busy_last_stall", 32'(busy), 1);
        wait_cyc(e + 257); #1;
        chk("t4_busy_abort", 32'(busy), 0);
        chk("t4_done_abort", 32'(done), 0);
        m_valid = 4'b1111;
        step(); step();

        // 5) s_ready toggling 1,0,1,0 with a 2-beat burst on master 3
        e = cyc;
        ml[3]  = 4'd1;
        req_in = 4'b1000;
        exp_beat.push_back('{own: 2'd3, data: 32'hCAFE_0001});
        exp_beat.push_back('{own: 2'd3, data: 32'hCAFE_0002});
        exp_done.push_back('{val: 4'b1000, cyc: e + 5});
        wait_cyc(e + 2); req_in = 4'b0000; s_ready = 1'b1; md[3] = 32'hCAFE_0001; #1;
        chk("t5_m_ready_hi", 32'(m_ready), 32'h8);
        wait_cyc(e + 3); s_ready = 1'b0; md[3] = 32'hDEAD_BEEF; #1;
        chk("t5_m_ready_lo", 32'(m_ready), 0);
        chk("t5_busy_wait", 32'(busy), 1);
        wait_cyc(e + 4); s_ready = 1'b1; md[3] = 32'hCAFE_0002; #1;
        chk("t5_m_ready_hi2", 32'(m_ready), 32'h8);
        wait_cyc(e + 5); s_ready = 1'b0; #1;
        chk("t5_busy_end", 32'(busy), 0);
        wait_cyc(e + 6); s_ready = 1'b1;
        step();

        // 6) Reset during beat 2 of an 8-beat burst
        e = cyc;
        ml[0]  = 4'd7;
        req_in = 4'b0001;
        exp_beat.push_back('{own: 2'd0, data: md[0]});
        wait_cyc(e + 3); rst_n = 1'b0; #1;
        chk("t6_busy_rst", 32'(busy), 0);
        chk("t6_done_rst", 32'(done), 0);
        chk("t6_req_out_rst", 32'(req_out), 32'h1);
        chk("t6_s_valid_rst", 32'(s_valid), 0);
        wait_cyc(e + 4); rst_n = 1'b1; #1;
        chk("t6_req_out_rel", 32'(req_out), 32'h1);
        chk("t6_busy_rel", 32'(busy), 0);
        req_in = 4'b0000;
        repeat (5) step();
        chk("t6_busy_final", 32'(busy), 0);

        // Every expected event must have been observed
        chk("left_beats", exp_beat.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("left_gnt_err", exp_gerr.size(), 0);
        chk("left_tmo_err", exp_tmo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
